// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-serial memory arbiter: access sizes, FSM states,
// bus owners, the IO region tag and the word/byte range macros.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV

`define WORD_RANGE 31:0
`define RAM_DATA_RANGE 7:0

package mem_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] IO_HI_DEFAULT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // Number of bus bytes for an LS size code; the unused code falls back to a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

`endif

// File: rtl/mem_arbiter.sv
// Grants the fetch or load/store port, serialises its access into little-endian
// byte transactions on the 8-bit RAM/IO bus and returns the assembled word.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_HI = IO_HI_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [`RAM_DATA_RANGE]  ram_data_in,
  output logic [`RAM_DATA_RANGE]  ram_data_out,
  output logic [`WORD_RANGE]      ram_address_out,
  output logic                    ram_rw_signal_out,
  input  logic                    io_buffer_full,
  input  logic                    if_req_in,
  input  logic [`WORD_RANGE]      if_addr_in,
  output logic                    if_ready_out,
  output logic [`WORD_RANGE]      if_data_out,
  input  logic                    ls_req_in,
  input  logic                    ls_rw_in,
  input  logic [1:0]              ls_size_in,
  input  logic [`WORD_RANGE]      ls_addr_in,
  input  logic [`WORD_RANGE]      ls_data_in,
  output logic                    ls_ready_out,
  output logic [`WORD_RANGE]      ls_data_out,
  input  logic                    rollback_in
);

  state_e             state_q;
  owner_e             owner_q;
  logic [2:0]         nbytes_q;
  logic [2:0]         idx_q;
  logic [`WORD_RANGE] base_q;
  logic [`WORD_RANGE] wdata_q;
  logic [`WORD_RANGE] acc_q;
  logic [`WORD_RANGE] acc_d;
  logic [`WORD_RANGE] if_data_q;
  logic [`WORD_RANGE] ls_data_q;
  logic               if_ready_q;
  logic               ls_ready_q;

  logic [2:0]            rd_idx_s;
  logic [`WORD_RANGE]    addr_s;
  logic [`RAM_DATA_RANGE] wbyte_s;
  logic                  rw_s;
  logic                  io_stall_s;

  // Bus drive. While frozen in a read, the address of the byte still owed is
  // re-driven so its data is on ram_data_in again when the capture resumes.
  always_comb begin
    addr_s     = 32'd0;
    wbyte_s    = 8'd0;
    rw_s       = 1'b0;
    io_stall_s = 1'b0;
    if (!rdy && (idx_q != 3'd0)) begin
      rd_idx_s = idx_q - 3'd1;
    end else begin
      rd_idx_s = idx_q;
    end
    case (state_q)
      ST_READ: begin
        if (rd_idx_s < nbytes_q) begin
          addr_s = base_q + {29'd0, rd_idx_s};
        end else begin
          addr_s = 32'd0;
        end
      end
      ST_WRITE: begin
        addr_s = base_q + {29'd0, idx_q};
        case (idx_q[1:0])
          2'd0:    wbyte_s = wdata_q[7:0];
          2'd1:    wbyte_s = wdata_q[15:8];
          2'd2:    wbyte_s = wdata_q[23:16];
          2'd3:    wbyte_s = wdata_q[31:24];
          default: wbyte_s = 8'd0;
        endcase
        io_stall_s = (addr_s[17:16] == IO_HI) && io_buffer_full;
        rw_s       = rdy && !io_stall_s;
      end
      default: begin
        addr_s = 32'd0;
      end
    endcase
  end

  // Accumulator with the byte owed for address idx-1 merged in.
  always_comb begin
    acc_d = acc_q;
    case (idx_q)
      3'd1:    acc_d[7:0]   = ram_data_in;
      3'd2:    acc_d[15:8]  = ram_data_in;
      3'd3:    acc_d[23:16] = ram_data_in;
      3'd4:    acc_d[31:24] = ram_data_in;
      default: acc_d = acc_q;
    endcase
  end

  // Arbitration and transfer FSM with registered completion pulses and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      nbytes_q   <= 3'd0;
      idx_q      <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      acc_q      <= 32'd0;
      if_data_q  <= 32'd0;
      ls_data_q  <= 32'd0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
    end else if (rdy) begin
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= 3'd0;
          acc_q <= 32'd0;
          if (ls_req_in && !ls_ready_q) begin
            owner_q  <= OWN_LS;
            base_q   <= ls_addr_in;
            wdata_q  <= ls_data_in;
            nbytes_q <= size_bytes(ls_size_in);
            state_q  <= ls_rw_in ? ST_WRITE : ST_READ;
          end else if (if_req_in && !if_ready_q && !rollback_in) begin
            owner_q  <= OWN_IF;
            base_q   <= if_addr_in;
            wdata_q  <= 32'd0;
            nbytes_q <= 3'd4;
            state_q  <= ST_READ;
          end
        end
        ST_READ: begin
          if ((owner_q == OWN_IF) && rollback_in) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
          end else begin
            acc_q <= acc_d;
            if (idx_q == nbytes_q) begin
              state_q <= ST_IDLE;
              if (owner_q == OWN_IF) begin
                if_ready_q <= 1'b1;
                if_data_q  <= acc_d;
              end else begin
                ls_ready_q <= 1'b1;
                ls_data_q  <= acc_d;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          if (!io_stall_s) begin
            if (idx_q == (nbytes_q - 3'd1)) begin
              state_q    <= ST_IDLE;
              ls_ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_address_out   = addr_s;
  assign ram_data_out      = wbyte_s;
  assign ram_rw_signal_out = rw_s;
  assign if_ready_out      = if_ready_q & ~rollback_in;
  assign if_data_out       = if_data_q;
  assign ls_ready_out      = ls_ready_q;
  assign ls_data_out       = ls_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter against a registered-read RAM
// and a shadow memory model of the expected contents.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  ram_data_in, ram_data_out;
  logic [31:0] ram_address_out;
  logic        ram_rw_signal_out, io_buffer_full;
  logic        if_req_in, if_ready_out, ls_req_in, ls_rw_in, ls_ready_out, rollback_in;
  logic [31:0] if_addr_in, if_data_out, ls_addr_in, ls_data_in, ls_data_out;
  logic [1:0]  ls_size_in;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
    .ram_address_out(ram_address_out), .ram_rw_signal_out(ram_rw_signal_out),
    .io_buffer_full(io_buffer_full),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_ready_out(if_ready_out), .if_data_out(if_data_out),
    .ls_req_in(ls_req_in), .ls_rw_in(ls_rw_in), .ls_size_in(ls_size_in),
    .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
    .ls_ready_out(ls_ready_out), .ls_data_out(ls_data_out),
    .rollback_in(rollback_in)
  );

  always #5 clk = ~clk;

  // RAM: 4K bytes folded from the address, read data valid the cycle after the address.
  bit [7:0]    ram [4096];
  bit          ram_wr [4096];
  bit [7:0]    sh [4096];
  bit          sh_wr [4096];
  logic        poke_en = 1'b0;
  logic [31:0] poke_a;
  logic [7:0]  poke_d;

  function automatic int midx(input logic [31:0] a);
    return int'({a[17:16], a[13:12], a[7:0]});
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    logic [11:0] v;
    v = i[11:0];
    return v[7:0] ^ {v[11:8], 4'h3} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (poke_en) begin
      ram[midx(poke_a)]    <= poke_d;
      ram_wr[midx(poke_a)] <= 1'b1;
    end else if (ram_rw_signal_out) begin
      ram[midx(ram_address_out)]    <= ram_data_out;
      ram_wr[midx(ram_address_out)] <= 1'b1;
    end
    ram_data_in <= ram_wr[midx(ram_address_out)] ? ram[midx(ram_address_out)]
                                                 : init_byte(midx(ram_address_out));
  end

  function automatic logic [7:0] sh_byte(input logic [31:0] a);
    return sh_wr[midx(a)] ? sh[midx(a)] : init_byte(midx(a));
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input int nb);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = sh_byte(a + i);
    return v;
  endfunction

  task automatic sh_store(input logic [31:0] a, input logic [31:0] d, input int nb);
    for (int i = 0; i < nb; i++) begin
      sh[midx(a + i)]    = d[8*i +: 8];
      sh_wr[midx(a + i)] = 1'b1;
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    sh[midx(a)] = d; sh_wr[midx(a)] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scenario configuration and per-cycle record (cycle 0 = first cycle request is visible).
  bit          c_if, c_lrw, c_noise;
  int          c_ls_at, c_io_lo, c_io_hi, c_rdy_lo, c_rdy_hi, c_rb_at, c_rst_at;
  logic [31:0] c_ia, c_la, c_ld;
  logic [1:0]  c_lsz;
  logic [31:0] r_addr [128];
  logic [7:0]  r_wd [128];
  logic        r_rw [128];
  int          first_if, first_ls, n_if, n_ls;
  logic [31:0] got_if, got_ls;
  logic [39:0] wq [$];

  task automatic cfg_clear();
    c_if = 1'b0; c_lrw = 1'b0; c_noise = 1'b0; c_ls_at = -1;
    c_io_lo = 200; c_io_hi = -1; c_rdy_lo = 200; c_rdy_hi = -1;
    c_rb_at = -1; c_rst_at = -1;
    c_ia = 32'd0; c_la = 32'd0; c_ld = 32'd0; c_lsz = 2'b00;
  endtask

  task automatic run(input int n);
    first_if = -1; first_ls = -1; n_if = 0; n_ls = 0;
    got_if = 32'd0; got_ls = 32'd0;
    wq.delete();
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 0 && c_if) begin
        if_req_in = 1'b1; if_addr_in = c_ia;
      end
      if (k == c_ls_at) begin
        ls_req_in = 1'b1; ls_rw_in = c_lrw; ls_size_in = c_lsz;
        ls_addr_in = c_la; ls_data_in = c_ld;
      end
      if (c_noise) begin
        rdy = ($urandom_range(0, 3) != 0);
        io_buffer_full = ($urandom_range(0, 3) == 0);
      end else begin
        rdy = !(k >= c_rdy_lo && k <= c_rdy_hi);
        io_buffer_full = (k >= c_io_lo && k <= c_io_hi);
      end
      rollback_in = (k == c_rb_at);
      if (k == c_rb_at) if_req_in = 1'b0;
      rst = (k == c_rst_at);
      if (k == c_rst_at) begin
        if_req_in = 1'b0; ls_req_in = 1'b0;
      end
      @(negedge clk);
      r_addr[k] = ram_address_out;
      r_wd[k]   = ram_data_out;
      r_rw[k]   = ram_rw_signal_out;
      if (ram_rw_signal_out) wq.push_back({ram_address_out, ram_data_out});
      if (if_ready_out) n_if++;
      if (ls_ready_out) n_ls++;
      if (if_ready_out && first_if < 0) begin
        first_if = k; got_if = if_data_out; if_req_in = 1'b0;
      end
      if (ls_ready_out && first_ls < 0) begin
        first_ls = k; got_ls = ls_data_out; ls_req_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    rdy = 1'b1; io_buffer_full = 1'b0; rollback_in = 1'b0; rst = 1'b0;
    if_req_in = 1'b0; ls_req_in = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; rollback_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = 32'd0; ls_req_in = 1'b0; ls_rw_in = 1'b0;
    ls_size_in = 2'b00; ls_addr_in = 32'd0; ls_data_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", ram_address_out, 32'd0);
    chk("rst_wdata", ram_data_out, 8'd0);
    chk("rst_rw", ram_rw_signal_out, 1'b0);
    chk("rst_if_rdy", if_ready_out, 1'b0);
    chk("rst_ls_rdy", ls_ready_out, 1'b0);
    chk("rst_if_data", if_data_out, 32'd0);
    chk("rst_ls_data", ls_data_out, 32'd0);
    rst = 1'b0;
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h05);
    poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);

    // Plain IF word read
    cfg_clear(); c_if = 1'b1; c_ia = 32'h1000;
    run(10);
    for (int i = 1; i <= 4; i++) begin
      chk("if_addr", r_addr[i], 32'h1000 + i - 1);
      chk("if_rw", r_rw[i], 1'b0);
    end
    chk("if_lat", first_if, 6);
    chk("if_data", got_if, 32'h0000_0513);
    chk("if_pulses", n_if, 1);

    // Simultaneous IF and LS word store: LS first, IF follows and sees the new word
    cfg_clear(); c_if = 1'b1; c_ia = 32'h2000;
    c_ls_at = 0; c_lrw = 1'b1; c_lsz = 2'b10; c_la = 32'h2000; c_ld = 32'hDEAD_BEEF;
    run(16);
    for (int i = 1; i <= 4; i++) begin
      chk("sw_rw", r_rw[i], 1'b1);
      chk("sw_addr", r_addr[i], 32'h2000 + i - 1);
      chk("sw_byte", r_wd[i], c_ld[8*(i-1) +: 8]);
    end
    chk("sw_lat", first_ls, 5);
    chk("sw_if_first_addr", r_addr[6], 32'h2000);
    chk("sw_if_lat", first_if, 11);
    chk("sw_if_data", got_if, 32'hDEAD_BEEF);
    sh_store(32'h2000, 32'hDEAD_BEEF, 4);

    // IO byte store held off by a full UART buffer
    cfg_clear(); c_ls_at = 0; c_lrw = 1'b1; c_lsz = 2'b00; c_la = 32'h0003_0000;
    c_ld = 32'h0000_0041; c_io_lo = 1; c_io_hi = 3;
    run(10);
    for (int i = 1; i <= 3; i++) chk("io_stall_rw", r_rw[i], 1'b0);
    chk("io_nwrites", wq.size(), 1);
    if (wq.size() > 0) chk("io_write", wq[0], {32'h0003_0000, 8'h41});
    chk("io_lat", first_ls, 5);
    sh_store(32'h0003_0000, 32'h41, 1);

    // Rollback of an IF read while an LS halfword load waits
    cfg_clear(); c_if = 1'b1; c_ia = 32'h1000; c_ls_at = 1; c_lsz = 2'b01;
    c_la = 32'h2002; c_rb_at = 2;
    run(12);
    chk("rb_idle_addr", r_addr[3], 32'd0);
    chk("rb_idle_rw", r_rw[3], 1'b0);
    chk("rb_no_if_rdy", n_if, 0);
    chk("rb_lh_lat", first_ls, 7);
    chk("rb_lh_data", got_ls, exp_load(32'h2002, 2));

    // rdy low for two cycles inside a word read and a word store
    cfg_clear(); c_if = 1'b1; c_ia = 32'h1000; c_rdy_lo = 2; c_rdy_hi = 3;
    run(12);
    chk("rdy_rd_lat", first_if, 8);
    chk("rdy_rd_data", got_if, 32'h0000_0513);
    cfg_clear(); c_ls_at = 0; c_lrw = 1'b1; c_lsz = 2'b10; c_la = 32'h1010;
    c_ld = 32'h1234_5678; c_rdy_lo = 2; c_rdy_hi = 3;
    run(12);
    chk("rdy_wr_lat", first_ls, 7);
    chk("rdy_wr_n", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) chk("rdy_wr_byte", wq[i], {32'h1010 + i, c_ld[8*i +: 8]});
    end
    sh_store(32'h1010, 32'h1234_5678, 4);
    cfg_clear(); c_if = 1'b1; c_ia = 32'h1010;
    run(10);
    chk("rdy_wr_readback", got_if, 32'h1234_5678);

    // Address wrap at the top of the address space
    cfg_clear(); c_if = 1'b1; c_ia = 32'hFFFF_FFFE;
    run(10);
    chk("wrap_addr2", r_addr[3], 32'd0);
    chk("wrap_addr3", r_addr[4], 32'd1);
    chk("wrap_data", got_if, exp_load(32'hFFFF_FFFE, 4));

    // Randomised traffic with random rdy and UART-full noise
    for (int t = 0; t < 30; t++) begin
      int          op;
      int          nb;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 2));
      nb = 1 << sz;
      a = ($urandom_range(0, 3) == 0) ? (32'h0003_0000 | 32'($urandom_range(0, 255)))
                                      : 32'($urandom_range(0, 255));
      d = $urandom;
      cfg_clear(); c_noise = 1'b1;
      if (op == 0) begin
        c_if = 1'b1; c_ia = a;
        run(80);
        chk("rnd_if_done", first_if >= 0, 1'b1);
        chk("rnd_if_data", got_if, exp_load(a, 4));
      end else if (op == 1) begin
        c_ls_at = 0; c_lrw = 1'b0; c_lsz = sz; c_la = a;
        run(80);
        chk("rnd_ld_done", first_ls >= 0, 1'b1);
        chk("rnd_ld_data", got_ls, exp_load(a, nb));
        chk("rnd_ld_nowr", wq.size(), 0);
      end else begin
        c_ls_at = 0; c_lrw = 1'b1; c_lsz = sz; c_la = a; c_ld = d;
        run(80);
        chk("rnd_st_done", first_ls >= 0, 1'b1);
        chk("rnd_st_n", wq.size(), nb);
        for (int i = 0; i < nb; i++) begin
          if (i < wq.size()) chk("rnd_st_byte", wq[i], {a + i, d[8*i +: 8]});
        end
        sh_store(a, d, nb);
      end
    end

    // Reset in cycle 2 of a word store abandons it
    cfg_clear(); c_ls_at = 0; c_lrw = 1'b1; c_lsz = 2'b10; c_la = 32'h1020;
    c_ld = 32'hCAFE_F00D; c_rst_at = 2;
    run(8);
    chk("rstw_addr", r_addr[3], 32'd0);
    chk("rstw_wd", r_wd[3], 8'd0);
    chk("rstw_rw", r_rw[3], 1'b0);
    chk("rstw_no_rdy", n_ls, 0);
    chk("rstw_if_data", if_data_out, 32'd0);
    chk("rstw_ls_data", ls_data_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
